uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Round-robin scheduler sharing one simplex UART transmitter among NUM_REQ byte producers.
//   Accepts one byte at a time over valid/ready, pulses the UART send strobe with that byte,
//   then holds off for a full frame time, because the UART exposes no busy flag.
//   Sits between debug/status producers and the UART; its o_send/o_frame drive the UART's i_send/i_frame.
// PARAMETERS
//   ClockFrequency  50_000_000  system clock in Hz; must match the UART instance
//   BaudRate        115200      line rate; must match the UART instance
//   NUM_REQ         4           number of requesters, >= 2
//   GUARD_TICKS     2           extra idle cycles appended after each frame window
//   Derived: TicksPerBit = ClockFrequency/BaudRate (integer divide); FRAME_CYCLES = 10*TicksPerBit + GUARD_TICKS
// PORTS
//   CLK          in   1            system clock, rising edge
//   RST          in   1            asynchronous reset, active-high
//   i_req_valid  in   NUM_REQ      bit n: requester n has a byte to send
//   i_req_data   in   8*NUM_REQ    byte of requester n at [8n+7:8n]
//   o_req_ready  out  NUM_REQ      one-hot accept; transfer on valid&ready at a rising edge
//   o_send       out  1            one-cycle send strobe to the UART
//   o_frame      out  8            byte for the UART; valid while o_send=1 and held until next accept
//   o_busy       out  1            1 whenever state != IDLE
//   o_grant_id   out  max(1,$clog2(NUM_REQ))  index of last accepted requester
// BEHAVIOUR
//   Reset (RST=1, async): state=IDLE, o_send=0, o_frame=0, o_busy=0, o_grant_id=0,
//     last_grant=NUM_REQ-1, so requester 0 has top priority first. o_req_ready=0 while RST=1.
//   The UART's active-low reset is driven from ~RST at the top level. A mid-frame reset aborts both blocks together.
//   FSM states: IDLE -> SEND -> WAIT -> IDLE.
//   IDLE: priority search starts at (last_grant+1) mod NUM_REQ and wraps.
//     The first requester with valid=1 gets o_req_ready asserted combinationally in the same cycle.
//     At that edge: latch the byte into o_frame, set last_grant/o_grant_id to that index, go to SEND.
//     No valid requesters: stay in IDLE, all ready=0.
//   SEND: o_send=1 for exactly this one cycle; load the counter with FRAME_CYCLES-1; go to WAIT.
//   WAIT: decrement the counter each cycle. When it reads 0, go to IDLE on the next edge.
//     o_req_ready=0 for the whole WAIT state.
//   Timing: accept at edge T -> o_send high in cycle T+1 -> WAIT covers FRAME_CYCLES cycles
//     -> IDLE again at T+2+FRAME_CYCLES. Minimum accept-to-accept spacing is FRAME_CYCLES+2 cycles.
//   This spacing covers the UART's 10*TicksPerBit-cycle frame plus its 1 load cycle,
//     so o_send never hits a UART that is still sending.
//   Counter width: $clog2(FRAME_CYCLES+1) bits. No overflow is possible.
//   valid may drop before acceptance with no side effect. After a byte is accepted it is never replayed.
//   Data only needs to be stable in the accept cycle.
//   Simultaneous valids: exactly one ready bit per accept. Losers keep valid and are served in rotation.
//     No requester waits more than NUM_REQ-1 frames once valid.
//   i_req_valid=0 throughout: o_send stays 0 and o_frame holds its last value.
// TESTING (defaults: TicksPerBit=434, FRAME_CYCLES=4342)
//   1. Requester 0 sends 0xA5 from idle -> ready[0]=1 in the same cycle; o_send=1 for 1 cycle next
//      with o_frame=0xA5; o_busy=1 for 4343 cycles. UART line decodes to start,1,0,1,0,0,1,0,1,stop.
//   2. All 4 valid continuously with data 0x10..0x13 -> grant order 0,1,2,3,0.
//      Accepts exactly 4344 cycles apart; the UART line decodes 0x10,0x11,0x12,0x13,0x10 intact.
//   3. Only req2 valid, then req1 and req3 together while busy -> order 2, 3, 1 (rotation wraps).
//   4. Valid raised during WAIT -> o_req_ready stays 0 and o_send stays 0 until IDLE.
//      Accepted in the first IDLE cycle.
//   5. RST pulse 1000 cycles into WAIT -> o_busy, o_send, o_frame, o_grant_id are 0 immediately.
//      The UART line returns to 1. After release, req3 and req0 valid -> req0 granted first.
//   6. Back-to-back stress, 200 random bytes from random requesters -> the byte stream decoded
//      from the UART line equals the accept log, with no o_send while the UART is mid-frame.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin scheduler that shares one simplex UART transmitter among
//   NUM_REQ byte producers. One byte is accepted at a time over valid/ready.
//   The byte is presented to the UART with a one-cycle send strobe. The block
//   then stays off the line for a full frame time plus a guard interval,
//   because the UART has no busy flag.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active-high
//   i_req_valid  per-requester "byte available"
//   i_req_data   byte of requester n at [8n+7:8n]
//   o_req_ready  one-hot accept; a transfer happens on valid&ready at a rising edge
//   o_send       one-cycle send strobe to the UART (drives its i_send)
//   o_frame      byte for the UART (drives its i_frame); held until the next accept
//   o_busy       high whenever the scheduler is not idle
//   o_grant_id   index of the last accepted requester
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int NUM_REQ        = 4,
  parameter int GUARD_TICKS    = 2,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_send,
  output logic [7:0]           o_frame,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id
);

  localparam int TICKS_PER_BIT = ClockFrequency / BaudRate;
  // Start + 8 data + stop bits, plus idle guard cycles after the stop bit.
  localparam int FRAME_CYCLES  = 10 * TICKS_PER_BIT + GUARD_TICKS;
  localparam int CNT_W         = $clog2(FRAME_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       frame_q, frame_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic [7:0]       pick_data;

  // --------------------------------------------------------------------------
  // Round-robin search. It starts one past the last grant and wraps, so the
  // requester just served has the lowest priority next time.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so that
    // no path leaves it unassigned; an unassigned path would infer a latch.
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(last_q) + 1 + i) % NUM_REQ);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == ID_W'(i)) pick_data = i_req_data[8*i +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop
      // samples values from before the edge, whatever the statement order.
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (found) state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // Ready is gated by RST so that no requester sees an accept while the block
  // is held in reset, even though the state flops already read IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    o_req_ready = '0;
    if (state_q == ST_IDLE && found && !RST) o_req_ready[pick] = 1'b1;
    o_send = (state_q == ST_SEND);
    o_busy = (state_q != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath: captured byte, grant bookkeeping and the frame-time counter
  // --------------------------------------------------------------------------
  always_comb begin
    frame_d = frame_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          frame_d = pick_data;
          grant_d = pick;
          last_d  = pick;
        end
      end
      ST_SEND: cnt_d = CNT_LOAD;
      ST_WAIT: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the datapath registers are reset too. A mid-frame reset must
      // leave o_frame and o_grant_id at zero, and last_q must restart the
      // rotation at requester 0.
      cnt_q   <= '0;
      frame_q <= '0;
      grant_q <= '0;
      last_q  <= LAST_INIT;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign o_frame    = frame_q;
  assign o_grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. It uses a reduced clock/baud ratio
//   (TicksPerBit = 10) so that frame windows stay short. Expected grants come
//   from a round-robin reference function. Expected timing comes from the frame
//   arithmetic. In the random phase, an accept log is compared against the
//   bytes seen on o_send.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int N      = 4;
  localparam int IW     = 2;
  localparam int GUARD  = 2;
  localparam int TPB    = CLK_HZ / BAUD;
  localparam int FC     = 10 * TPB + GUARD;
  localparam int BOUND  = 4 * FC;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   o_req_ready;
  logic           o_send;
  logic [7:0]     o_frame;
  logic           o_busy;
  logic [IW-1:0]  o_grant_id;

  int        checks = 0;
  int        errors = 0;
  int        model_last = N - 1;
  longint    last_acc_t = 0;
  bit [7:0]  acc_log[$];
  bit [7:0]  sent_log[$];

  uart_tx_arbiter #(
    .ClockFrequency(CLK_HZ),
    .BaudRate      (BAUD),
    .NUM_REQ       (N),
    .GUARD_TICKS   (GUARD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_req_valid(valid),
    .i_req_data (data),
    .o_req_ready(o_req_ready),
    .o_send     (o_send),
    .o_frame    (o_frame),
    .o_busy     (o_busy),
    .o_grant_id (o_grant_id)
  );

  always #5 CLK = ~CLK;

  // Reference arbitration rule: the first valid requester after the last grant,
  // wrapping around.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[IW'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*N-1:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  // Waits (bounded) for any ready bit. The sample point is 1 unit after a
  // falling edge.
  task automatic wait_ready(output logic [N-1:0] rdy, output int waited);
    waited = 0;
    rdy = o_req_ready;
    while (rdy == '0 && waited < BOUND) begin
      @(negedge CLK); #1;
      waited++;
      rdy = o_req_ready;
    end
  endtask

  // Lets the accept edge happen and returns the cycle spacing to the previous
  // accept.
  task automatic do_accept(output int gap);
    @(posedge CLK);
    gap = int'(($time - last_acc_t) / 10);
    last_acc_t = $time;
  endtask

  // Follows one busy window after an accept. clear_mask drops valids in the
  // first cycle. raise_mask is OR-ed in at busy cycle raise_at.
  task automatic observe(input logic [N-1:0] clear_mask, input int raise_at,
                         input logic [N-1:0] raise_mask, output int busy_len,
                         output int send_len, output int send_pos,
                         output logic [7:0] frame, output bit ready_seen);
    busy_len = 0; send_len = 0; send_pos = -1; frame = '0; ready_seen = 1'b0;
    for (int k = 0; k < FC + 10; k++) begin
      @(negedge CLK);
      if (k == 0) valid = valid & ~clear_mask;
      if (k == raise_at) valid = valid | raise_mask;
      #1;
      if (!o_busy) break;
      busy_len++;
      if (o_send) begin
        send_len++;
        if (send_pos < 0) send_pos = k;
        frame = o_frame;
      end
      if (|o_req_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    valid = '1;
    data  = 32'h4433_2211;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({o_busy, o_send, o_frame, o_grant_id} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=000", {o_busy, o_send, o_frame, o_grant_id});
    end
    checks++;
    if (o_req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0000", o_req_ready);
    end
    @(negedge CLK);
    valid = '0;
    RST = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== '0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got ready=%b busy=%b exp 0000/0", o_req_ready, o_busy);
    end
    model_last = N - 1;
  endtask

  task automatic test_all_valid();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] rdy;
    int w, gap, bl, sl, sp;
    logic [7:0] fr;
    bit rs;
    @(negedge CLK);
    data  = {8'h13, 8'h12, 8'h11, 8'h10};
    valid = '1;
    #1;
    for (int t = 0; t < 5; t++) begin
      wait_ready(rdy, w);
      checks++;
      if (rdy !== N'(1 << order[t])) begin
        errors++;
        $display("FAIL all_valid_grant%0d got=%b exp=%b", t, rdy, N'(1 << order[t]));
      end
      do_accept(gap);
      model_last = order[t];
      if (t > 0) begin
        checks++;
        if (gap !== FC + 2) begin
          errors++;
          $display("FAIL all_valid_spacing%0d got=%0d exp=%0d", t, gap, FC + 2);
        end
      end
      observe((t == 4) ? '1 : '0, -1, '0, bl, sl, sp, fr, rs);
      checks++;
      if (fr !== 8'h10 + 8'(order[t]) || sl !== 1) begin
        errors++;
        $display("FAIL all_valid_frame%0d got=%h/%0d exp=%h/1", t, fr, sl, 8'h10 + 8'(order[t]));
      end
      checks++;
      if (o_grant_id !== IW'(order[t])) begin
        errors++;
        $display("FAIL all_valid_grant_id%0d got=%0d exp=%0d", t, o_grant_id, order[t]);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] rdy;
    int w, gap, bl, sl, sp;
    logic [7:0] fr;
    bit rs, bad;
    valid = 4'b0001;
    data  = 32'h0000_00A5;
    #1;
    wait_ready(rdy, w);
    checks++;
    if (rdy !== 4'b0001 || w !== 0) begin
      errors++;
      $display("FAIL single_ready got=%b wait=%0d exp=0001 wait=0", rdy, w);
    end
    do_accept(gap);
    model_last = 0;
    observe(4'b0001, -1, '0, bl, sl, sp, fr, rs);
    checks++;
    if (sp !== 0 || sl !== 1 || fr !== 8'hA5) begin
      errors++;
      $display("FAIL single_send got pos=%0d len=%0d frame=%h exp 0/1/a5", sp, sl, fr);
    end
    checks++;
    if (bl !== FC + 1) begin
      errors++;
      $display("FAIL single_busy_len got=%0d exp=%0d", bl, FC + 1);
    end
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK); #1;
      if (o_send !== 1'b0 || o_frame !== 8'hA5 || o_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_hold got bad=1 exp=0 (send=%b frame=%h)", o_send, o_frame);
    end
  endtask

  task automatic test_rotation_wrap();
    logic [N-1:0] rdy;
    int w, gap, bl, sl, sp, exp;
    logic [7:0] fr;
    bit rs;
    data  = {$urandom};
    valid = 4'b0100;
    #1;
    wait_ready(rdy, w);
    exp = rr_pick(valid, model_last);
    checks++;
    if (rdy !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_first got=%b exp=0100", rdy);
    end
    do_accept(gap);
    model_last = exp;
    observe(4'b0100, 5, 4'b1010, bl, sl, sp, fr, rs);
    checks++;
    if (rs !== 1'b0 || sl !== 1) begin
      errors++;
      $display("FAIL wait_ready_low got ready_seen=%b sends=%0d exp 0/1", rs, sl);
    end
    wait_ready(rdy, w);
    checks++;
    if (rdy !== 4'b1000 || w !== 0) begin
      errors++;
      $display("FAIL wrap_second got=%b wait=%0d exp=1000 wait=0", rdy, w);
    end
    do_accept(gap);
    model_last = 3;
    observe(4'b1000, -1, '0, bl, sl, sp, fr, rs);
    checks++;
    if (fr !== byte_of(data, 3)) begin
      errors++;
      $display("FAIL wrap_second_frame got=%h exp=%h", fr, byte_of(data, 3));
    end
    wait_ready(rdy, w);
    checks++;
    if (rdy !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_third got=%b exp=0010", rdy);
    end
    do_accept(gap);
    model_last = 1;
    observe(4'b0010, -1, '0, bl, sl, sp, fr, rs);
    checks++;
    if (fr !== byte_of(data, 1)) begin
      errors++;
      $display("FAIL wrap_third_frame got=%h exp=%h", fr, byte_of(data, 1));
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [N-1:0] rdy;
    int w, gap, bl, sl, sp;
    logic [7:0] fr;
    bit rs;
    data  = {$urandom};
    valid = 4'b0010;
    #1;
    wait_ready(rdy, w);
    do_accept(gap);
    repeat (50) @(negedge CLK);
    RST   = 1'b1;
    valid = 4'b1001;
    #1;
    checks++;
    if ({o_busy, o_send, o_frame, o_grant_id} !== 12'h000 || o_req_ready !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h ready=%b exp=000/0000",
               {o_busy, o_send, o_frame, o_grant_id}, o_req_ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_last = N - 1;
    #1;
    wait_ready(rdy, w);
    checks++;
    if (rdy !== N'(1 << rr_pick(valid, model_last)) || rdy !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first got=%b exp=0001", rdy);
    end
    do_accept(gap);
    model_last = 0;
    observe(4'b0001, -1, '0, bl, sl, sp, fr, rs);
    checks++;
    if (fr !== byte_of(data, 0) || bl !== FC + 1) begin
      errors++;
      $display("FAIL midreset_frame got=%h/%0d exp=%h/%0d", fr, bl, byte_of(data, 0), FC + 1);
    end
    wait_ready(rdy, w);
    checks++;
    if (rdy !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_second got=%b exp=1000", rdy);
    end
    do_accept(gap);
    model_last = 3;
    observe(4'b1000, -1, '0, bl, sl, sp, fr, rs);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rdy;
    int w, gap, bl, sl, sp, exp, idle, mism;
    logic [7:0] fr;
    bit rs;
    acc_log.delete();
    sent_log.delete();
    for (int i = 0; i < 200; i++) begin
      valid = '0;
      idle  = $urandom_range(0, 2);
      repeat (idle) @(negedge CLK);
      valid = N'($urandom_range(1, (1 << N) - 1));
      data  = {$urandom};
      #1;
      exp = rr_pick(valid, model_last);
      wait_ready(rdy, w);
      checks++;
      if (rdy !== N'(1 << exp) || w !== 0) begin
        errors++;
        $display("FAIL b2b_grant%0d got=%b wait=%0d exp=%b wait=0", i, rdy, w, N'(1 << exp));
      end
      acc_log.push_back(byte_of(data, exp));
      do_accept(gap);
      model_last = exp;
      if (i > 0) begin
        checks++;
        if (gap !== FC + 2 + idle) begin
          errors++;
          $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, gap, FC + 2 + idle);
        end
      end
      observe('1, -1, '0, bl, sl, sp, fr, rs);
      if (sl > 0) sent_log.push_back(fr);
      checks++;
      if (sl !== 1 || bl !== FC + 1 || rs !== 1'b0) begin
        errors++;
        $display("FAIL b2b_window%0d got sends=%0d busy=%0d ready_seen=%b exp 1/%0d/0",
                 i, sl, bl, rs, FC + 1);
      end
    end
    mism = 0;
    foreach (acc_log[k]) begin
      if (k >= sent_log.size() || sent_log[k] !== acc_log[k]) mism++;
    end
    checks++;
    if (mism !== 0 || sent_log.size() !== acc_log.size()) begin
      errors++;
      $display("FAIL b2b_stream got mismatches=%0d sent=%0d exp 0/%0d",
               mism, sent_log.size(), acc_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_single();
    test_rotation_wrap();
    test_mid_frame_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
